// File: rtl/layer_generator_if.sv
// Signal bundle between layer_generator (master) and the blocks stage (slave).
interface layer_generator_if;
  logic       module_en;
  logic       one_ms_tick;
  logic       jump_left;
  logic       jump_right;
  logic [0:6] layer_map_out;
  logic [0:6] block_type_out;
  logic       load_layer;
  logic       fill_done;

  modport master (
    input  module_en,
    input  one_ms_tick,
    input  jump_left,
    input  jump_right,
    output layer_map_out,
    output block_type_out,
    output load_layer,
    output fill_done
  );

  modport slave (
    output module_en,
    output one_ms_tick,
    output jump_left,
    output jump_right,
    input  layer_map_out,
    input  block_type_out,
    input  load_layer,
    input  fill_done
  );
endinterface

// File: rtl/layer_generator.sv
// Generates 7-column platform rows from a Galois LFSR with a guaranteed safe path,
// issues the initial fill through load_layer, then keeps a preview row ready for each jump.
module layer_generator #(
  parameter int unsigned NUM_LAYERS  = 5,
  parameter int unsigned FILL_GAP_MS = 300,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input logic               clk,
  input logic               rst_n,
  layer_generator_if.master bus
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam int FILL_W = $clog2(NUM_LAYERS + 1);
  localparam int TICK_W = $clog2(FILL_GAP_MS + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(NUM_LAYERS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FILL_GAP_MS - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FILL_GEN  = 3'd1;
  localparam logic [2:0] S_FILL_LOAD = 3'd2;
  localparam logic [2:0] S_FILL_WAIT = 3'd3;
  localparam logic [2:0] S_GEN       = 3'd4;
  localparam logic [2:0] S_READY     = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [2:0]        path_col_q, path_col_d;
  logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              pending_q, pending_d;
  logic [0:6]        map_q, map_d;
  logic [0:6]        type_q, type_d;
  logic              load_q, load_d;
  logic              fill_done_q, fill_done_d;

  logic [15:0] lfsr_nxt;
  logic [0:6]  row_map;
  logic [0:6]  row_type;
  logic [2:0]  path_nxt;
  logic        gen_row;
  logic        jump;

  assign jump = bus.jump_left | bus.jump_right;

  // Candidate row from the next LFSR value; the path column reflects off 1 and 5.
  always_comb begin
    lfsr_nxt = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    row_map  = '0;
    row_type = '0;
    for (int i = 0; i < 7; i++) begin
      row_map[i]  = lfsr_nxt[i] | lfsr_nxt[i+7];
      row_type[i] = row_map[i] & lfsr_nxt[i+7] & lfsr_nxt[14];
    end
    if (path_col_q == 3'd1) begin
      path_nxt = 3'd2;
    end else if (path_col_q == 3'd5) begin
      path_nxt = 3'd4;
    end else if (lfsr_nxt[15]) begin
      path_nxt = path_col_q + 3'd1;
    end else begin
      path_nxt = path_col_q - 3'd1;
    end
    row_map[path_nxt]  = 1'b1;
    row_type[path_nxt] = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    path_col_d  = path_col_q;
    fill_cnt_d  = fill_cnt_q;
    tick_cnt_d  = tick_cnt_q;
    pending_d   = pending_q;
    map_d       = map_q;
    type_d      = type_q;
    load_d      = 1'b0;
    fill_done_d = fill_done_q;
    gen_row     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.module_en) state_d = S_FILL_GEN;
      end
      S_FILL_GEN: begin
        gen_row = 1'b1;
        load_d  = 1'b1;
        state_d = S_FILL_LOAD;
      end
      S_FILL_LOAD: begin
        fill_cnt_d = fill_cnt_q + 1'b1;
        tick_cnt_d = '0;
        state_d    = S_FILL_WAIT;
      end
      S_FILL_WAIT: begin
        if (bus.one_ms_tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (tick_cnt_q == TICK_LAST) begin
            state_d = (fill_cnt_q == FILL_LAST) ? S_GEN : S_FILL_GEN;
          end
        end
      end
      S_GEN: begin
        gen_row     = 1'b1;
        fill_done_d = 1'b1;
        state_d     = S_READY;
        // A jump landing on the GEN cycle is held one-deep for the next READY.
        if (jump) pending_d = 1'b1;
      end
      S_READY: begin
        if (jump || pending_q) begin
          pending_d = 1'b0;
          state_d   = S_GEN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (gen_row) begin
      lfsr_d     = lfsr_nxt;
      path_col_d = path_nxt;
      map_d      = row_map;
      type_d     = row_type;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !bus.module_en) begin
      state_q     <= S_IDLE;
      lfsr_q      <= SEED_EFF;
      path_col_q  <= 3'd3;
      fill_cnt_q  <= '0;
      tick_cnt_q  <= '0;
      pending_q   <= 1'b0;
      map_q       <= '0;
      type_q      <= '0;
      load_q      <= 1'b0;
      fill_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      path_col_q  <= path_col_d;
      fill_cnt_q  <= fill_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      pending_q   <= pending_d;
      map_q       <= map_d;
      type_q      <= type_d;
      load_q      <= load_d;
      fill_done_q <= fill_done_d;
    end
  end

  assign bus.layer_map_out  = map_q;
  assign bus.block_type_out = type_q;
  assign bus.load_layer     = load_q;
  assign bus.fill_done      = fill_done_q;

endmodule

// File: tb/tb_layer_generator.sv
// Scoreboard bench for layer_generator: two instances (SEED=ACE1 and SEED=0) checked
// against one reference row model through the fill, play, jump queuing and re-enable.
module tb_layer_generator;

  localparam int NUM_LAYERS = 5;
  localparam int GAP        = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic module_en;
  logic one_ms_tick;
  logic jump_left;
  logic jump_right;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [0:6] map;
    logic [0:6] typ;
    logic [2:0] path;
  } row_t;

  row_t        exp_q[$];
  row_t        cur_row;
  logic [15:0] m_lfsr;
  logic [2:0]  m_path;

  layer_generator_if bus_a ();
  layer_generator_if bus_b ();

  assign bus_a.module_en   = module_en;
  assign bus_a.one_ms_tick = one_ms_tick;
  assign bus_a.jump_left   = jump_left;
  assign bus_a.jump_right  = jump_right;
  assign bus_b.module_en   = module_en;
  assign bus_b.one_ms_tick = one_ms_tick;
  assign bus_b.jump_left   = jump_left;
  assign bus_b.jump_right  = jump_right;

  layer_generator #(.NUM_LAYERS(NUM_LAYERS), .FILL_GAP_MS(GAP), .SEED(16'hACE1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  layer_generator #(.NUM_LAYERS(NUM_LAYERS), .FILL_GAP_MS(GAP), .SEED(16'h0000)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive inputs for the current cycle, then move to just after the next rising edge.
  task automatic applyStimulus(input bit en, input bit tick, input bit jl, input bit jr);
    module_en   = en;
    one_ms_tick = tick;
    jump_left   = jl;
    jump_right  = jr;
    @(posedge clk);
    #1;
  endtask

  task automatic modelNextRow(output row_t r);
    logic [15:0] nxt;
    logic [2:0]  np;
    nxt = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    for (int i = 0; i < 7; i++) begin
      r.map[i] = nxt[i] | nxt[i+7];
      r.typ[i] = r.map[i] & nxt[i+7] & nxt[14];
    end
    if (m_path == 3'd1)      np = 3'd2;
    else if (m_path == 3'd5) np = 3'd4;
    else if (nxt[15])        np = m_path + 3'd1;
    else                     np = m_path - 3'd1;
    r.map[np] = 1'b1;
    r.typ[np] = 1'b0;
    r.path    = np;
    m_lfsr    = nxt;
    m_path    = np;
  endtask

  task automatic checkRow(input string tag, input row_t r);
    checkOutput({tag, "_map_a"}, 32'(bus_a.layer_map_out), 32'(r.map));
    checkOutput({tag, "_type_a"}, 32'(bus_a.block_type_out), 32'(r.typ));
    checkOutput({tag, "_map_b"}, 32'(bus_b.layer_map_out), 32'(r.map));
    checkOutput({tag, "_type_b"}, 32'(bus_b.block_type_out), 32'(r.typ));
    checkOutput({tag, "_typemask_a"}, 32'(bus_a.block_type_out & ~bus_a.layer_map_out), 32'd0);
    checkOutput({tag, "_safe_a"}, {30'd0, bus_a.layer_map_out[r.path], bus_a.block_type_out[r.path]}, 32'd2);
  endtask

  task automatic checkLoad(input string tag, input bit exp);
    checkOutput({tag, "_a"}, 32'(bus_a.load_layer), 32'(exp));
    checkOutput({tag, "_b"}, 32'(bus_b.load_layer), 32'(exp));
  endtask

  task automatic checkFillDone(input string tag, input bit exp);
    checkOutput({tag, "_a"}, 32'(bus_a.fill_done), 32'(exp));
    checkOutput({tag, "_b"}, 32'(bus_b.fill_done), 32'(exp));
  endtask

  task automatic checkIdleOutputs(input string tag);
    row_t z;
    z = '0;
    checkOutput({tag, "_map_a"}, 32'(bus_a.layer_map_out), 32'(z.map));
    checkOutput({tag, "_type_a"}, 32'(bus_a.block_type_out), 32'(z.typ));
    checkOutput({tag, "_map_b"}, 32'(bus_b.layer_map_out), 32'(z.map));
    checkOutput({tag, "_type_b"}, 32'(bus_b.block_type_out), 32'(z.typ));
    checkLoad({tag, "_load"}, 1'b0);
    checkFillDone({tag, "_done"}, 1'b0);
  endtask

  // Starts from IDLE (reset or disabled) and walks the whole fill into READY.
  task automatic runFill(input bit noise);
    row_t r;
    row_t last;
    m_lfsr = 16'hACE1;
    m_path = 3'd3;
    exp_q.delete();
    last  = '0;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < NUM_LAYERS; k++) begin
      checkLoad("fill_gen_load", 1'b0);
      modelNextRow(r);
      exp_q.push_back(r);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkLoad("fill_load", 1'b1);
      checkFillDone("fill_done_early", 1'b0);
      last = exp_q.pop_front();
      checkRow("fill_row", last);
      applyStimulus(1'b1, (k == 0), noise, 1'b0);
      checkLoad("load_width", 1'b0);
      for (int t = 0; t < GAP; t++) begin
        for (int w = 0; w < 9; w++) begin
          applyStimulus(1'b1, 1'b0, noise && ($urandom_range(0, 1) == 1), noise && ($urandom_range(0, 1) == 1));
          checkLoad("fill_wait_load", 1'b0);
          checkRow("fill_hold", last);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      end
    end
    checkLoad("gen_load", 1'b0);
    checkFillDone("fill_done_gen", 1'b0);
    modelNextRow(r);
    exp_q.push_back(r);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkFillDone("fill_done_ready", 1'b1);
    last = exp_q.pop_front();
    checkRow("preview_row", last);
    for (int w = 0; w < 5; w++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkLoad("post_fill_load", 1'b0);
      checkFillDone("fill_done_hold", 1'b1);
      checkRow("preview_hold", last);
    end
    cur_row = last;
  endtask

  task automatic runPlay(input int n);
    row_t       r;
    logic [1:0] sel;
    for (int j = 0; j < n; j++) begin
      int idle;
      idle = int'($urandom_range(0, 2));
      for (int w = 0; w < idle; w++) begin
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        checkRow("play_hold", cur_row);
      end
      sel = 2'($urandom_range(1, 3));
      modelNextRow(r);
      exp_q.push_back(r);
      applyStimulus(1'b1, 1'b0, sel[0], sel[1]);
      checkRow("play_gen_cycle", cur_row);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      cur_row = exp_q.pop_front();
      checkRow("play_new_row", cur_row);
      checkLoad("play_load", 1'b0);
    end
  endtask

  task automatic runQueue();
    row_t r;
    // Two back-to-back jumps: the second is held while in GEN.
    modelNextRow(r);
    exp_q.push_back(r);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkRow("q2_gen", cur_row);
    modelNextRow(r);
    exp_q.push_back(r);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    cur_row = exp_q.pop_front();
    checkRow("q2_first", cur_row);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkRow("q2_pending_gen", cur_row);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    cur_row = exp_q.pop_front();
    checkRow("q2_second", cur_row);
    // Three back-to-back jumps yield only two rows.
    modelNextRow(r);
    exp_q.push_back(r);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkRow("q3_gen", cur_row);
    modelNextRow(r);
    exp_q.push_back(r);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    cur_row = exp_q.pop_front();
    checkRow("q3_first", cur_row);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkRow("q3_pending_gen", cur_row);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    cur_row = exp_q.pop_front();
    checkRow("q3_second", cur_row);
    for (int w = 0; w < 4; w++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkRow("q3_no_third", cur_row);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    module_en   = 1'b1;
    one_ms_tick = 1'b0;
    jump_left   = 1'b0;
    jump_right  = 1'b0;
    cur_row     = '0;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checkIdleOutputs("reset");
    end

    runFill(1'b0);
    runPlay(500);
    runQueue();

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checkIdleOutputs("disable");
    end

    runFill(1'b1);
    runPlay(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/layer_generator.md
# layer_generator

Upstream feeder for the `blocks` stage. It produces the 7-column platform rows and their hazard masks with a 16-bit LFSR, and guarantees a survivable path column from row to row. At game start it issues the initial fill of `NUM_LAYERS` rows through `load_layer` pulses. After that it keeps a fresh "next row" on its outputs, ready for `blocks` to latch on every jump.

## Interface
- `NUM_LAYERS`, 5, number of rows pushed during the initial fill.
- `FILL_GAP_MS`, 300, `one_ms_tick` pulses waited after each fill load (≥1).
- `SEED`, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'hACE1.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `module_en` in 1: game-running enable; low acts as a synchronous reset of all state.
- `one_ms_tick` in 1: single-cycle 1 ms strobe.
- `jump_left` in 1: player jump pulse, also the row-consumed strobe.
- `jump_right` in 1: player jump pulse, also the row-consumed strobe.
- `layer_map_out` out [0:6]: platform present per column; bit 0 is the leftmost column.
- `block_type_out` out [0:6]: 1 marks a fatal block; always 0 where the map bit is 0.
- `load_layer` out 1: single-cycle pulse that pushes the current outputs into `blocks`.
- `fill_done` out 1: high once the fill is complete and a preview row is valid.

## Operation
- **Reset and disable.** While `rst_n`=0 or `module_en`=0, on each clock: state=IDLE, lfsr=SEED, path_col=3, fill_cnt=0, tick_cnt=0, pending=0. Outputs: `layer_map_out`=0, `block_type_out`=0, `load_layer`=0, `fill_done`=0.
- **LFSR step.** Galois, right shift, mask 16'hB400: `nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 0)`. It advances exactly once per GEN-type cycle and holds otherwise.
- **Row build** (r = nxt), for column i = 0..6:
  - map[i] = r[i] | r[i+7]
  - type[i] = map[i] & r[i+7] & r[14]
- **Path column.** dir = r[15]. path_col moves +1 if dir=1, −1 if dir=0. It is clamped to 1..5 by reflection: from 1 it always goes to 2; from 5 it always goes to 4.
- **Forced safe cell.** map[path_new]=1 and type[path_new]=0. Outputs and path_col are registered in the same cycle.
- **FSM states:**
  - IDLE: if `module_en`=1, go to FILL_GEN.
  - FILL_GEN: build a row, go to FILL_LOAD.
  - FILL_LOAD: `load_layer`=1, fill_cnt+1, tick_cnt=0, go to FILL_WAIT.
  - FILL_WAIT: count `one_ms_tick` pulses. When tick_cnt reaches FILL_GAP_MS:
    - if fill_cnt=NUM_LAYERS, go to GEN;
    - otherwise go to FILL_GEN.
  - GEN: build a row, go to READY. `fill_done` is set on exit and stays 1 until reset or disable.
  - READY: on (`jump_left` | `jump_right`) or pending=1, go to GEN and clear pending.
- **Jumps.**
  - Jumps in IDLE, FILL_GEN, FILL_LOAD and FILL_WAIT are ignored; no pending is set.
  - A jump arriving while in GEN sets pending (one-deep).
  - Further jumps while pending=1 are dropped.
  - `jump_left` and `jump_right` together count as one jump.
- No `load_layer` is issued after the fill. In play, `blocks` latches the outputs directly on the jump cycle.

## Timing
- Jump in READY at cycle N: `blocks` latches the old row at edge N. State is GEN during N+1. The new row is visible on the outputs from N+2.
- Output row is stable from its GEN edge until the next GEN edge.
- Fill sequence:
  - `module_en` rises at cycle 0 (IDLE sampled at edge 0). FILL_GEN runs at cycle 1 and the first `load_layer` appears at cycle 2.
  - Each later `load_layer` appears 2 cycles after the FILL_GAP_MS-th tick seen in FILL_WAIT.
  - `load_layer` is always exactly 1 cycle wide. Outputs during `load_layer` equal the row built in the preceding FILL_GEN.
  - Exactly NUM_LAYERS `load_layer` pulses occur per enable.
- A tick coinciding with the FILL_LOAD cycle is not counted.
- `module_en` dropping mid-fill or mid-play restarts from IDLE with SEED, so the row sequence repeats identically.

## Test plan
- **Reset.** Hold `rst_n`=0 with `module_en`=1 and random jumps → all outputs 0, no `load_layer`. Release → first `load_layer` 2 cycles later.
- **Fill sequence.** FILL_GAP_MS=2, ticks every 10 cycles → exactly 5 `load_layer` pulses, each 1 cycle wide. `fill_done` rises one cycle after the GEN following the 5th wait; no pulses after that.
- **Safe path.** Play with 500 random jumps → every row has a column c with map=1 and type=0. c differs by exactly 1 from the previous row's c and stays within 1..5. No type bit is ever set where the map bit is 0.
- **Jump queuing.** In READY, assert jumps at cycles N and N+1 → GEN at N+1, then READY, then GEN at N+3. Jumps at N, N+1, N+2 → only 2 rows generated.
- **Determinism and seed.** Disable then re-enable → identical sequence of `load_layer` rows to the first run. SEED=0 → same sequence as SEED=16'hACE1.
- **Ignored jumps during fill.** Jumps in FILL_WAIT → no extra row changes. `fill_done` timing is unchanged.
